imem_responder: RTL and testbench

Instruction-memory responder at the far end of the fetch address path: the program-counter register issues word addresses starting at 0x0000_3000, and this block answers each fetch with the stored instruction word after a fixed latency. It holds the instruction store, checks every address for alignment and range, and supports back-pressure on the response side. A separate write port loads program words, either from the bench or from a boot loader.

---
 rtl/imem_responder.sv | 130 +++++++++++++
 tb/tb_imem_responder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: answers each fetch with the stored word, or an
// error flag, a fixed number of cycles after the request is accepted.
module imem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          ADDR_W      = 12,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_instr,
    output logic        resp_err,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // One past the last valid byte address, kept at 33 bits so a store that
    // ends at the top of the address space cannot wrap.
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    function automatic logic addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= BASE_ADDR) && ({1'b0, a} < END_ADDR);
    endfunction

    function automatic logic [ADDR_W-1:0] word_index(input logic [31:0] a);
        return ADDR_W'((a - BASE_ADDR) >> 2);
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q;
    logic        accept;
    logic        do_read;
    logic [31:0] read_addr;
    logic        read_ok;
    logic [31:0] read_word;

    logic [31:0] mem [DEPTH_WORDS];

    assign req_ready  = (state_q == IDLE) && reset;
    assign resp_valid = (state_q == RESP);

    // With LATENCY=1 the array is read on the accept edge, before addr_q holds
    // the request, so the live request address is used there instead.
    assign read_addr = (state_q == IDLE) ? req_addr : addr_q;
    assign read_ok   = addr_ok(read_addr);
    assign read_word = read_ok ? mem[word_index(read_addr)] : 32'h0;

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        do_read = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    cnt_d  = CNT_LOAD;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        do_read = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    do_read = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs, regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= 32'h0;
            resp_instr <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q <= req_addr;
            end
            if (do_read) begin
                resp_err   <= !read_ok;
                resp_instr <= read_word;
            end
        end
    end

    // NOTE: the array has no reset; clearing thousands of words is not wanted
    // and program contents must survive a reset. A write on the read edge
    // lands after the read, so that response carries the old word.
    always_ff @(posedge clk) begin
        if (reset && wr_en && addr_ok(wr_addr)) begin
            mem[word_index(wr_addr)] <= wr_data;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed scenarios plus a random mix
// of writes and fetches checked against a byte-address-keyed memory model.
module tb_imem_responder;

    localparam logic [31:0] BASE  = 32'h0000_3000;
    localparam int          DEPTH = 4096;
    localparam int          AW    = 12;
    localparam int          LAT   = 2;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        req_valid  = 1'b0;
    logic [31:0] req_addr   = 32'h0;
    logic        resp_ready = 1'b0;
    logic        wr_en      = 1'b0;
    logic [31:0] wr_addr    = 32'h0;
    logic [31:0] wr_data    = 32'h0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_instr;
    logic        resp_err;

    int errors = 0;
    int checks = 0;

    // Reference memory: byte address -> word, only for addresses written legally.
    logic [31:0] model [int unsigned];
    int unsigned keys[$];

    imem_responder #(
        .BASE_ADDR  (BASE),
        .DEPTH_WORDS(DEPTH),
        .ADDR_W     (AW),
        .LATENCY    (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_instr(resp_instr),
        .resp_err  (resp_err),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic bit legal(input logic [31:0] a);
        longint unsigned x;
        x = longint'(a);
        return (x % 4 == 0) && (x >= longint'(BASE)) && (x < longint'(BASE) + 4 * DEPTH);
    endfunction

    function automatic logic [31:0] expected_word(input logic [31:0] a);
        if (!legal(a)) return 32'h0;
        return model[a];
    endfunction

    function automatic logic [31:0] bad_addr();
        case ($urandom_range(2))
            0:       return BASE + ($urandom_range(DEPTH - 1) << 2) + $urandom_range(3, 1);
            1:       return $urandom_range(32'h0000_2FFF, 0);
            default: return $urandom_range(32'hFFFF_FFFF, 32'h0000_7000);
        endcase
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (legal(a)) begin
            if (!model.exists(a)) keys.push_back(a);
            model[a] = d;
        end
    endtask

    // One full fetch transaction; optionally writes (ca, cd) on the array-read edge.
    task automatic fetch(input logic [31:0] a, input int hold, input bit coll,
                         input logic [31:0] ca, input logic [31:0] cd,
                         output logic [31:0] instr, output logic err, output int stall);
        int lat;
        req_valid = 1'b1; req_addr = a; stall = 0;
        while (!req_ready && stall < 100) begin
            @(posedge clk); #1; stall++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        lat = 0;
        while (!resp_valid && lat < 100) begin
            if (coll && lat == LAT - 1) begin
                wr_en = 1'b1; wr_addr = ca; wr_data = cd;
            end
            @(posedge clk); #1;
            wr_en = 1'b0;
            lat++;
            if (!resp_valid && req_ready !== 1'b0) begin
                errors++;
                $display("FAIL wait_ready addr=%h req_ready=%b required=0", a, req_ready);
            end
        end
        if (coll && legal(ca)) begin
            if (!model.exists(ca)) keys.push_back(ca);
            model[ca] = cd;
        end
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL latency addr=%h got=%0d required=%0d", a, lat, LAT);
        end
        instr = resp_instr;
        err   = resp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checks++;
            if (resp_valid !== 1'b1 || resp_instr !== instr || resp_err !== err || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable cycle=%0d valid=%b instr=%h err=%b required valid=1 instr=%h err=%b",
                         i, resp_valid, resp_instr, resp_err, instr, err);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_instr !== instr || resp_err !== err) begin
            errors++;
            $display("FAIL handshake valid=%b ready=%b instr=%h err=%b required valid=0 ready=1 instr=%h err=%b",
                     resp_valid, req_ready, resp_instr, resp_err, instr, err);
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_instr !== 32'h0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_values ready=%b valid=%b instr=%h err=%b required all zero",
                     req_ready, resp_valid, resp_instr, resp_err);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release req_ready=%b required=1", req_ready);
        end
    endtask

    task automatic test_basic();
        logic [31:0] instr; logic err; int stall;
        wr(32'h0000_3000, 32'h3C08_1234);
        fetch(32'h0000_3000, 0, 1'b0, 32'h0, 32'h0, instr, err, stall);
        checks++;
        if (instr !== 32'h3C08_1234 || err !== 1'b0) begin
            errors++;
            $display("FAIL basic instr=%h err=%b required instr=3c081234 err=0", instr, err);
        end
    endtask

    task automatic test_range();
        logic [31:0] addrs [4];
        logic [31:0] instr, exp; logic err; int stall;
        addrs = '{32'h0000_2FFC, 32'h0000_6FFC, 32'h0000_7000, 32'hFFFF_FFFC};
        wr(32'h0000_6FFC, 32'hDEAD_BEEF);
        foreach (addrs[i]) begin
            exp = expected_word(addrs[i]);
            fetch(addrs[i], 0, 1'b0, 32'h0, 32'h0, instr, err, stall);
            checks++;
            if (instr !== exp || err !== !legal(addrs[i])) begin
                errors++;
                $display("FAIL range addr=%h instr=%h err=%b required instr=%h err=%b",
                         addrs[i], instr, err, exp, !legal(addrs[i]));
            end
        end
    endtask

    task automatic test_misalign();
        logic [31:0] instr; logic err; int stall;
        wr(32'h0000_3004, 32'h1234_5678);
        wr(32'h0000_3006, 32'h1111_1111);
        fetch(32'h0000_3002, 0, 1'b0, 32'h0, 32'h0, instr, err, stall);
        checks++;
        if (instr !== 32'h0 || err !== 1'b1) begin
            errors++;
            $display("FAIL misalign_fetch instr=%h err=%b required instr=0 err=1", instr, err);
        end
        fetch(32'h0000_3004, 0, 1'b0, 32'h0, 32'h0, instr, err, stall);
        checks++;
        if (instr !== 32'h1234_5678 || err !== 1'b0) begin
            errors++;
            $display("FAIL misalign_write instr=%h err=%b required instr=12345678 err=0", instr, err);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] instr; logic err; int stall;
        wr(32'h0000_3008, 32'h0F0F_5A5A);
        fetch(32'h0000_3008, 5, 1'b0, 32'h0, 32'h0, instr, err, stall);
        checks++;
        if (instr !== 32'h0F0F_5A5A || err !== 1'b0) begin
            errors++;
            $display("FAIL backpressure instr=%h err=%b required instr=0f0f5a5a err=0", instr, err);
        end
        fetch(32'h0000_3000, 0, 1'b0, 32'h0, 32'h0, instr, err, stall);
        checks++;
        if (stall !== 0 || instr !== 32'h3C08_1234) begin
            errors++;
            $display("FAIL back_to_back stall=%0d instr=%h required stall=0 instr=3c081234", stall, instr);
        end
    endtask

    task automatic test_collision();
        logic [31:0] instr; logic err; int stall;
        wr(32'h0000_3010, 32'hAAAA_AAAA);
        fetch(32'h0000_3010, 0, 1'b1, 32'h0000_3010, 32'hBBBB_BBBB, instr, err, stall);
        checks++;
        if (instr !== 32'hAAAA_AAAA) begin
            errors++;
            $display("FAIL collision_old instr=%h required=aaaaaaaa", instr);
        end
        fetch(32'h0000_3010, 0, 1'b0, 32'h0, 32'h0, instr, err, stall);
        checks++;
        if (instr !== 32'hBBBB_BBBB) begin
            errors++;
            $display("FAIL collision_new instr=%h required=bbbbbbbb", instr);
        end
    endtask

    // Reset during WAIT (phase 0) and during RESP (phase 1); a write attempted
    // while reset is low must not land.
    task automatic test_reset_mid();
        logic [31:0] instr; logic err; int stall;
        wr(32'h0000_3020, 32'hC0DE_0020);
        for (int phase = 0; phase < 2; phase++) begin
            req_valid = 1'b1; req_addr = 32'h0000_3020;
            @(posedge clk); #1;
            req_valid = 1'b0;
            if (phase == 1) begin
                repeat (LAT) @(posedge clk);
                #1;
            end
            #2 reset = 1'b0;
            #1;
            checks++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b0 || resp_instr !== 32'h0 || resp_err !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid phase=%0d valid=%b ready=%b instr=%h err=%b required all zero",
                         phase, resp_valid, req_ready, resp_instr, resp_err);
            end
            wr_en = 1'b1; wr_addr = 32'h0000_3020; wr_data = 32'hBAD0_BAD0;
            @(posedge clk); #1;
            wr_en = 1'b0;
            @(posedge clk); #1;
            reset = 1'b1;
            #1;
            checks++;
            if (req_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_mid_release phase=%0d req_ready=%b required=1", phase, req_ready);
            end
            for (int i = 0; i < LAT + 3; i++) begin
                @(posedge clk); #1;
                checks++;
                if (resp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stale_response phase=%0d cycle=%0d resp_valid=%b required=0", phase, i, resp_valid);
                end
            end
            fetch(32'h0000_3020, 0, 1'b0, 32'h0, 32'h0, instr, err, stall);
            checks++;
            if (instr !== 32'hC0DE_0020 || err !== 1'b0) begin
                errors++;
                $display("FAIL reset_refetch phase=%0d instr=%h err=%b required instr=c0de0020 err=0", phase, instr, err);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, instr, exp; logic err; int stall;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(3))
                0: wr(BASE + ($urandom_range(DEPTH - 1) << 2), $urandom);
                1: wr(bad_addr(), $urandom);
                default: begin
                    a = ($urandom_range(3) == 0) ? bad_addr() : keys[$urandom_range(keys.size() - 1)];
                    exp = expected_word(a);
                    fetch(a, $urandom_range(3), 1'b0, 32'h0, 32'h0, instr, err, stall);
                    checks++;
                    if (instr !== exp || err !== !legal(a)) begin
                        errors++;
                        $display("FAIL random addr=%h instr=%h err=%b required instr=%h err=%b",
                                 a, instr, err, exp, !legal(a));
                    end
                end
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_range();
        test_misalign();
        test_back_to_back();
        test_collision();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
